// File: rtl/path_read_buffer.sv
// Multi-path DRAM read buffer: circular burst store with path-boundary tracking on both sides.
// Latency: cut-through 1 cycle push-to-head; with PATHBUF_STORE_FWD_EN the head is held until its whole path is stored.
// Backpressure: DRAM cannot stall, so a burst arriving while full is dropped and flagged in sticky o_overflow.
module path_read_buffer #(
    parameter int Width      = 512,
    parameter int PathBursts = 64,
    parameter int NumPaths   = 2,
    parameter int OccWidth   = $clog2(PathBursts*NumPaths+1),
    parameter int PthWidth   = $clog2(NumPaths+1)
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [Width-1:0]    i_in_data,
    input  logic                i_in_valid,
    output logic                o_in_accept,
    output logic [Width-1:0]    o_out_data,
    output logic                o_out_send,
    input  logic                i_out_ready,
    output logic                o_out_path_last,
    output logic [OccWidth-1:0] o_occupancy,
    output logic [PthWidth-1:0] o_complete_paths,
    output logic                o_overflow
);

    localparam int D    = PathBursts * NumPaths;
    localparam int PtrW = (D > 1) ? $clog2(D) : 1;
    localparam int BtW  = $clog2(PathBursts);

    localparam logic [OccWidth-1:0] CntFull  = OccWidth'(D);
    localparam logic [PtrW-1:0]     PtrLast  = PtrW'(D - 1);
    localparam logic [BtW-1:0]      BeatLast = BtW'(PathBursts - 1);

    logic [Width-1:0]    r_mem [D];
    logic [PtrW-1:0]     r_wp;
    logic [PtrW-1:0]     r_rp;
    logic [OccWidth-1:0] r_cnt;
    logic [BtW-1:0]      r_ib;
    logic [BtW-1:0]      r_ob;
    logic [PthWidth-1:0] r_cp;
    logic                r_ovf;

    logic w_accept;
    logic w_send;
    logic w_push;
    logic w_pop;
    logic w_ib_last;
    logic w_ob_last;

    // Accept is combinational from the count so a freed slot is only usable the cycle after the pop.
    assign w_accept  = i_reset_n & (r_cnt != CntFull);
`ifdef PATHBUF_STORE_FWD_EN
    // The path currently draining stays counted until its last burst pops, so successors stay hidden until whole.
    assign w_send    = (r_cnt != '0) & (r_cp != '0);
`else
    assign w_send    = (r_cnt != '0);
`endif
    assign w_push    = i_in_valid & w_accept;
    assign w_pop     = w_send & i_out_ready;
    assign w_ib_last = (r_ib == BeatLast);
    assign w_ob_last = (r_ob == BeatLast);

    assign o_in_accept      = w_accept;
    assign o_out_send       = w_send;
    assign o_out_data       = r_mem[r_rp];
    assign o_out_path_last  = w_send & w_ob_last;
    assign o_occupancy      = r_cnt;
    assign o_complete_paths = r_cp;
    assign o_overflow       = r_ovf;

    // Burst storage; contents need no reset because count and pointers qualify them.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wp] <= i_in_data;
        end
    end

    // Pointers, occupancy, beat counters, complete-path count and sticky overflow.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ib  <= '0;
            r_ob  <= '0;
            r_cp  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= (r_wp == PtrLast) ? '0 : r_wp + PtrW'(1);
                r_ib <= w_ib_last ? '0 : r_ib + BtW'(1);
            end
            if (w_pop) begin
                r_rp <= (r_rp == PtrLast) ? '0 : r_rp + PtrW'(1);
                r_ob <= w_ob_last ? '0 : r_ob + BtW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + OccWidth'(1);
                2'b01:   r_cnt <= r_cnt - OccWidth'(1);
                default: r_cnt <= r_cnt;
            endcase
            case ({w_push & w_ib_last, w_pop & w_ob_last})
                2'b10:   r_cp <= r_cp + PthWidth'(1);
                2'b01:   r_cp <= r_cp - PthWidth'(1);
                default: r_cp <= r_cp;
            endcase
            if (i_in_valid & ~w_accept) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_path_read_buffer.sv
// Self-checking bench for path_read_buffer (Width=16, PathBursts=4, NumPaths=2).
// Reference model: a burst queue plus total push/pop counts since reset.
// Honours PATHBUF_STORE_FWD_EN in the model the same way the design build does.
module tb_path_read_buffer;

    localparam int W  = 16;
    localparam int PB = 4;
    localparam int NP = 2;
    localparam int D  = PB * NP;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_accept;
    logic [W-1:0]  out_data;
    logic          out_send;
    logic          out_ready;
    logic          out_path_last;
    logic [3:0]    occupancy;
    logic [1:0]    complete_paths;
    logic          overflow;

    path_read_buffer #(
        .Width(W), .PathBursts(PB), .NumPaths(NP), .OccWidth(4), .PthWidth(2)
    ) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_in_data(in_data),
        .i_in_valid(in_valid),
        .o_in_accept(in_accept),
        .o_out_data(out_data),
        .o_out_send(out_send),
        .i_out_ready(out_ready),
        .o_out_path_last(out_path_last),
        .o_occupancy(occupancy),
        .o_complete_paths(complete_paths),
        .o_overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    logic [W-1:0] q[$];
    int           pushed;
    int           popped;
    bit           m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_cp();
        return pushed / PB - popped / PB;
    endfunction

    function automatic bit m_send();
`ifdef PATHBUF_STORE_FWD_EN
        return (q.size() != 0) && (m_cp() != 0);
`else
        return q.size() != 0;
`endif
    endfunction

    function automatic bit m_accept();
        return q.size() != D;
    endfunction

    // One clock: drive at negedge, check model vs DUT, then advance the model past the rising edge.
    task automatic cycle(input bit v, input logic [W-1:0] d, input bit r);
        bit e_acc;
        bit e_send;
        bit push;
        bit pop;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        e_acc  = m_accept();
        e_send = m_send();
        chk("accept", 32'(in_accept), 32'(e_acc));
        chk("send", 32'(out_send), 32'(e_send));
        if (e_send) begin
            chk("data", 32'(out_data), 32'(q[0]));
            chk("path_last", 32'(out_path_last), 32'((popped % PB) == PB - 1));
        end else begin
            chk("path_last_idle", 32'(out_path_last), 32'(0));
        end
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("complete", 32'(complete_paths), 32'(m_cp()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        push = v && e_acc;
        pop  = e_send && r;
        @(posedge clk);
        if (v && !e_acc) m_ovf = 1'b1;
        if (pop) begin
            void'(q.pop_front());
            popped++;
        end
        if (push) begin
            q.push_back(d);
            pushed++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_occupancy", 32'(occupancy), 32'(0));
        chk("rst_send", 32'(out_send), 32'(0));
        chk("rst_accept", 32'(in_accept), 32'(0));
        chk("rst_complete", 32'(complete_paths), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_path_last", 32'(out_path_last), 32'(0));
        q.delete();
        pushed = 0;
        popped = 0;
        m_ovf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        q.delete();
        pushed = 0;
        popped = 0;
        m_ovf  = 1'b0;
        #12;
        do_reset();

        // Cut-through stream of one path with consumer always ready.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, W'(i), 1'b1);
`ifndef PATHBUF_STORE_FWD_EN
            if (i == 1) begin
                #2;
                chk("ct_first_send", 32'(out_send), 32'(1));
                chk("ct_first_data", 32'(out_data), 32'(1));
            end
`endif
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        #2;
        chk("ct_final_complete", 32'(complete_paths), 32'(0));
        chk("ct_final_occ", 32'(occupancy), 32'(0));

`ifdef PATHBUF_STORE_FWD_EN
        // Gated release: nothing visible until the fourth burst lands.
        do_reset();
        for (int i = 1; i <= 3; i++) cycle(1'b1, W'(i), 1'b1);
        #2;
        chk("gate_hold_send", 32'(out_send), 32'(0));
        cycle(1'b1, W'(4), 1'b1);
        #2;
        chk("gate_rel_send", 32'(out_send), 32'(1));
        chk("gate_rel_data", 32'(out_data), 32'(1));
        chk("gate_rel_complete", 32'(complete_paths), 32'(1));
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
`endif

        // Fill to capacity, overflow on the ninth burst, then recover.
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, W'(16'h100 + i), 1'b0);
        #2;
        chk("full_occ", 32'(occupancy), 32'(8));
        chk("full_complete", 32'(complete_paths), 32'(2));
        chk("full_accept", 32'(in_accept), 32'(0));
        chk("full_overflow", 32'(overflow), 32'(1));
        cycle(1'b1, W'(16'h200), 1'b1);
        #2;
        chk("recover_accept", 32'(in_accept), 32'(1));
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);

        // Last push of path B coincides with last pop of path A.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, W'(16'h300 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, W'(16'h307), 1'b1);
        #2;
        chk("simul_complete", 32'(complete_paths), 32'(1));
        chk("simul_occ", 32'(occupancy), 32'(4));
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

        // Five paths through the ring, consumer toggling, producer never overrunning.
        do_reset();
        budget = 0;
        while (pushed < 5 * PB && budget < 400) begin
            cycle(m_accept() && ($urandom_range(0, 3) != 0), W'($urandom), budget[0]);
            budget++;
        end
        chk("wrap_pushed", 32'(pushed), 32'(5 * PB));
        budget = 0;
        while (q.size() != 0 && budget < 40) begin
            cycle(1'b0, '0, 1'b1);
            budget++;
        end
        chk("wrap_drained", 32'(q.size()), 32'(0));
        chk("wrap_overflow", 32'(overflow), 32'(0));

        // Reset in the middle of a path discards the partial path.
        cycle(1'b1, W'(16'h400), 1'b0);
        cycle(1'b1, W'(16'h401), 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(16'h500 + i), 1'b0);
        #2;
        chk("midrst_complete", 32'(complete_paths), 32'(1));
        chk("midrst_occ", 32'(occupancy), 32'(4));

        // Unconstrained random traffic, overflow allowed.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 1) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/path_read_buffer.md
# path_read_buffer

Multi-path DRAM read buffer between the DRAM read-data port and the ORAM backend's read-data input. It stores up to `NumPaths` complete ORAM paths of `PathBursts` bursts each and tracks path boundaries on both sides. It can optionally hold data back until a whole path has arrived, so backend timing does not depend on DRAM read timing. It also reports occupancy, path completion and overflow.

## Interface
- `Width`, 512, burst data width (DDRDWidth)
- `PathBursts`, 64, bursts per ORAM path (PathSize_DRBursts); ≥2
- `NumPaths`, 2, whole paths buffered; depth D = PathBursts*NumPaths
- `OccWidth`, clog2(D+1), occupancy counter width
- `PthWidth`, clog2(NumPaths+1), path counter width

- `Clock` in 1: sole clock, rising edge
- `ResetN` in 1: asynchronous, active-low reset
- `InData` in Width: DRAM read burst
- `InValid` in 1: burst present (DRAM does not stall)
- `InAccept` out 1: buffer can take a burst this cycle
- `OutData` out Width: head burst, first-word-fall-through
- `OutSend` out 1: OutData valid
- `OutReady` in 1: consumer takes head when OutSend&OutReady
- `OutPathLast` out 1: head is the last burst of its path
- `Occupancy` out OccWidth: bursts stored
- `CompletePaths` out PthWidth: paths fully written, not fully drained
- `Overflow` out 1: sticky; a burst arrived while InAccept=0

## Operation
- Storage is a circular RAM of D entries with write pointer WP, read pointer RP and count C. Pointers wrap from D-1 to 0.
- Push = InValid & InAccept. It writes InData at WP, then WP+1.
- Pop = OutSend & OutReady. It advances RP by 1.
- C updates by +Push−Pop. Simultaneous push and pop leaves C unchanged.
- InAccept = (C != D) while ResetN is high.
- InValid & ~InAccept sets Overflow. The burst is dropped and no counter changes. Overflow clears only on reset.
- Input beat counter IB runs 0..PathBursts-1 and increments on Push. A Push at IB = PathBursts-1 wraps IB to 0 and raises CompletePaths by 1.
- Output beat counter OB runs 0..PathBursts-1 and increments on Pop. A Pop at OB = PathBursts-1 wraps OB to 0 and lowers CompletePaths by 1.
- If a path completes and a path finishes draining in the same cycle, CompletePaths is unchanged.
- OutPathLast = OutSend & (OB == PathBursts-1).
- Without gating: OutSend = (C != 0).
- With gating: OutSend = (C != 0) & (CompletePaths != 0). The path being drained still counts as complete until its last burst pops. This holds partial successor paths back until they complete.
- OutData = RAM[RP] (asynchronous read). When OutSend = 0, OutData is don't-care.

## Timing
- Reset values (ResetN low, asynchronous): WP=RP=C=IB=OB=0, CompletePaths=0, Overflow=0, OutSend=0, OutPathLast=0, Occupancy=0, InAccept=0.
- InAccept goes to 1 on the first Clock edge-free cycle after ResetN is released (combinational from C).
- Cut-through latency: a burst pushed at edge N is on OutData with OutSend=1 in cycle N+1.
- Gated latency: the first burst of a path becomes visible in the cycle after the edge that pushes that path's last burst.
- Full (C=D): InAccept=0 in that cycle, even if a pop happens in the same cycle. The freed entry is accepted from the next cycle.
- Empty (C=0): OutSend=0. Push and pop never coincide with the empty condition.
- Reset mid-path: all contents and the partial-path state are discarded. No recovery of in-flight bursts.

## Configuration
- Macro: `PATHBUF_STORE_FWD_EN`.
- Defined: gated (store-and-forward) release as above.
- Undefined: cut-through release. CompletePaths and OutPathLast are still maintained.

## Test plan
Use Width=16, PathBursts=4, NumPaths=2 (D=8).

- **Cut-through, gating off.** Push 0x1..0x4 back-to-back with OutReady=1 → OutData shows 0x1..0x4 in cycles 1..4 after the first push. OutPathLast=1 only with 0x4. Final CompletePaths=0.
- **Gating on.** Push 0x1..0x3 → OutSend stays 0. Push 0x4 → next cycle OutSend=1, OutData=0x1, CompletePaths=1.
- **Fill, overflow and recovery.** OutReady=0, push 9 bursts → Occupancy=8, CompletePaths=2, InAccept=0, Overflow=1, and the 9th burst is absent on readout. Then set OutReady=1 and push → InAccept returns 1 the cycle after the first pop.
- **Simultaneous events.** Push the 4th burst of path B in the same cycle the 4th burst of path A pops → CompletePaths unchanged (1), Occupancy unchanged.
- **Wrap-around.** Stream 5 paths, OutReady toggling 1/0 every cycle → output order equals input order and Overflow=0.
- **Reset mid-path.** Push 2 bursts, pulse ResetN low for 1 cycle → Occupancy=0, OutSend=0, IB=0. The next 4 pushes form a complete path (CompletePaths=1).
